fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of riscy32_single; sits directly upstream of control/datapath.
//  Owns the PC, handshakes with instruction memory, holds the fetched word and splits out op/funct3/funct7.
//  Applies PCSrc/PCTarget from control when execute acks the instruction.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  TIMEOUT    16             max WAIT cycles for imem_rvalid before fetch_fault (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address (= pc)
//  imem_ready   in   1   imem accepts request this cycle
//  imem_rvalid  in   1   imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  PCSrc        in   1   from control: 1 = take PCTarget, 0 = pc+4
//  PCTarget     in   32  branch/jump target from datapath
//  instr_ack    in   1   execute has consumed instr this cycle
//  instr_valid  out  1   instr/pc/op/funct3/funct7 valid
//  instr        out  32  held instruction word
//  pc           out  32  address of held instruction
//  pc_plus4     out  32  pc + 4 (mod 2^32), combinational
//  op           out  7   instr[6:0]
//  funct3       out  3   instr[14:12]
//  funct7       out  1   instr[30]
//  fetch_fault  out  1   sticky fault flag
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (nop), timeout cnt=0;
//    imem_req=0, instr_valid=0, fetch_fault=0.
//  FSM states: IDLE, FETCH, WAIT, ISSUE, FAULT; all outputs registered except pc_plus4/op/funct3/funct7.
//  IDLE : -> FETCH next cycle unconditionally.
//  FETCH: imem_req=1, imem_addr=pc; on imem_ready -> WAIT, cnt=0. imem_rvalid ignored in FETCH.
//  WAIT : imem_req=0; cnt++ each cycle. On imem_rvalid: instr<=imem_rdata -> ISSUE.
//         Else when cnt==TIMEOUT-1 -> FAULT. rvalid and timeout same cycle: rvalid wins.
//  ISSUE: instr_valid=1; instr/pc stable until ack. On instr_ack: pc<=PCSrc ? {PCTarget[31:1],1'b0} : pc_plus4;
//         -> FETCH. PCSrc/PCTarget sampled only in the ack cycle.
//  FAULT: fetch_fault=1, instr_valid=0, imem_req=0; exits only by reset.
//  Min latency: FETCH->ISSUE = 2 cycles with ready and rvalid each 1 cycle; one instr per 3 cycles max.
//  pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  instr_ack while instr_valid=0 is ignored. Reset mid-WAIT discards pending response; stray rvalid
//  outside WAIT ignored.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: in ISSUE ack cycle, if PCSrc=1 and PCTarget[1]=1 -> FAULT
//    (pc not updated, fetch_fault=1 next cycle).
//  Not defined: next pc low bits forced to 2'b00 ({PCTarget[31:2],2'b00}); never faults on alignment.
// TESTING
//  T1 reset: rst_n=0 mid-run -> imem_req=0, instr_valid=0, pc=RESET_PC, fetch_fault=0 immediately.
//  T2 sequential: ready/rvalid 1-cycle, rdata=32'h00500093, ack -> op=7'h13, funct3=0, next imem_addr=0x4.
//  T3 branch: ISSUE at pc=0x10, PCSrc=1, PCTarget=0x40, ack -> next imem_addr=0x40; PCSrc=0 -> 0x14.
//  T4 hold: withhold instr_ack 5 cycles -> instr_valid=1, instr/pc unchanged, no imem_req.
//  T5 timeout: TIMEOUT=4, no rvalid -> fetch_fault=1 after 4 WAIT cycles; rvalid on cnt=3 -> ISSUE.
//  T6 misalign: PCTarget=0x42, PCSrc=1, ack -> EN: fetch_fault=1; not EN: next imem_addr=0x40.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: riscy32_single fetch stage (PC, imem handshake, instr hold/split).
// Optional FETCH_MISALIGN_TRAP_EN: misaligned taken target faults instead of being masked.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        instr_ack,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        fetch_fault
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, ISSUE, FAULT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pc_n, instr_n;
  logic [31:0]   tgt;
  logic          misalign;
  logic          tgt_unused;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[30];

  // Low target bits are either trapped on or silently masked.
`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt      = {PCTarget[31:1], 1'b0};
  assign misalign = PCSrc & PCTarget[1];
`else
  assign tgt      = {PCTarget[31:2], 2'b00};
  assign misalign = 1'b0;
`endif
  assign tgt_unused = ^PCTarget[1:0];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    instr_n = instr;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (imem_ready) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        cnt_n = cnt + 1'b1;
        if (imem_rvalid) begin
          instr_n = imem_rdata;
          state_n = ISSUE;
        end else if (cnt == CNT_LAST) begin
          state_n = FAULT;
        end
      end
      ISSUE: begin
        if (instr_ack) begin
          if (misalign) begin
            state_n = FAULT;
          end else begin
            pc_n    = PCSrc ? tgt : pc_plus4;
            state_n = FETCH;
          end
        end
      end
      FAULT: state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0013;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      instr       <= instr_n;
      imem_req    <= (state_n == FETCH);
      instr_valid <= (state_n == ISSUE);
      fetch_fault <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random imem/execute stimulus against a transaction-level
// fetch model; a negedge monitor scores fetch addresses, issues and faults.
module tb_fetch_unit;

  localparam int          TO  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_RUN = 0, M_WAIT = 1, M_ISSUE = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        PCSrc, instr_ack, instr_valid;
  logic [31:0] PCTarget, instr, pc, pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7, fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_ack(instr_ack), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .op(op),
    .funct3(funct3), .funct7(funct7), .fetch_fault(fetch_fault)
  );

  typedef struct {
    bit          fault;
    logic [31:0] pc;
    logic [31:0] ins;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] addr_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(bit f, logic [31:0] p, logic [31:0] i, int c);
    ev_t e;
    e.fault = f; e.pc = p; e.ins = i; e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFC;
      1: return 32'h0000_0042;
      2: return 32'h0000_0040;
      default: return $urandom;
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    ev_t cur;
    bit  pv, pf;
    cur = mk_ev(0, 0, 0, 0);
    pv = 0; pf = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; pf = 0;
      end else begin
        if (imem_req && imem_ready) begin
          if (addr_q.size() == 0) chk("spurious_fetch", 1, 0);
          else chk("fetch_addr", imem_addr, addr_q.pop_front());
        end
        if (instr_valid && !pv) begin
          if (exp_q.size() == 0 || exp_q[0].fault) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("issue_cycle", cyc, cur.cyc);
            chk("issue_pc", pc, cur.pc);
            chk("issue_instr", instr, cur.ins);
            chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
            chk("op", {25'b0, op}, {25'b0, cur.ins[6:0]});
            chk("funct3", {29'b0, funct3}, {29'b0, cur.ins[14:12]});
            chk("funct7", {31'b0, funct7}, {31'b0, cur.ins[30]});
          end
        end else if (instr_valid) begin
          chk("hold_instr", instr, cur.ins);
          chk("hold_pc", pc, cur.pc);
        end
        if (instr_valid) chk("req_in_issue", {31'b0, imem_req}, 0);
        if (fetch_fault && !pf) begin
          if (exp_q.size() == 0 || !exp_q[0].fault) begin
            chk("unexpected_fault", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("fault_cycle", cyc, cur.cyc);
            chk("fault_valid", {31'b0, instr_valid}, 0);
            chk("fault_req", {31'b0, imem_req}, 0);
          end
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("missing_event", 0, 1);
          void'(exp_q.pop_front());
        end
        pv = instr_valid;
        pf = fetch_fault;
      end
    end
  end

  // Driver + reference model
  int          mode, w, k, acc, icyc, h, fcyc;
  bit          rdy_q, req_q, trap;
  logic [31:0] pcm, mask;

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 0; imem_rvalid = 0; instr_ack = 0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_fault", {31'b0, fetch_fault}, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, NOP);
    exp_q.delete();
    addr_q.delete();
    pcm = RPC;
    addr_q.push_back(pcm);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = M_RUN;
    rdy_q = 0; req_q = 0;
  endtask

  initial begin
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    instr_ack = 0; PCSrc = 0; PCTarget = 0;
    w = 0; k = 0; acc = 0; icyc = 0; h = 0; fcyc = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mask = 32'h1;
`else
    mask = 32'h3;
`endif
    #2;
    do_reset();
    for (int it = 0; it < 4000; it++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 63) == 0 ||
          (mode == M_FAULT && cyc >= fcyc + 2)) begin
        do_reset();
        continue;
      end
      if (mode == M_RUN && rdy_q && req_q) begin
        mode = M_WAIT; w = 0; acc = cyc;
        k = $urandom_range(0, TO);
        if (k == TO) exp_q.push_back(mk_ev(1, pcm, 0, acc + TO));
      end
      imem_ready  = 1'($urandom_range(0, 1));
      imem_rvalid = ($urandom_range(0, 3) == 0);
      imem_rdata  = $urandom;
      instr_ack   = 1'($urandom_range(0, 1));
      PCSrc       = 1'($urandom_range(0, 1));
      PCTarget    = pick_target();
      case (mode)
        M_WAIT: begin
          if (k < TO && w == k) begin
            imem_rvalid = 1;
            exp_q.push_back(mk_ev(0, pcm, imem_rdata, cyc + 1));
            mode = M_ISSUE; icyc = cyc + 1;
            h = $urandom_range(0, 5);
          end else begin
            imem_rvalid = 0;
            if (w == TO - 1) begin
              mode = M_FAULT; fcyc = acc + TO;
            end
            w++;
          end
        end
        M_ISSUE: begin
          instr_ack = (cyc >= icyc + h);
          if (instr_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            trap = PCSrc && PCTarget[1];
`else
            trap = 0;
`endif
            if (trap) begin
              exp_q.push_back(mk_ev(1, pcm, 0, cyc + 1));
              mode = M_FAULT; fcyc = cyc + 1;
            end else begin
              pcm = PCSrc ? (PCTarget & ~mask) : pcm + 32'd4;
              addr_q.push_back(pcm);
              mode = M_RUN;
            end
          end
        end
        default: ;
      endcase
      rdy_q = imem_ready;
      req_q = imem_req;
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
